// File: rtl/asciiram_arbiter.sv
// asciiram_arbiter: shares a byte-wide ASCII RAM port between CPU word writes, split into byte lanes, and display scanner reads.
module asciiram_arbiter #(
  parameter int AW = 11
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          cpu_req,
  input  logic [31:0]   cpu_addr,
  input  logic [31:0]   cpu_wdata,
  input  logic [3:0]    cpu_be,
  output logic          cpu_ready,
  input  logic          disp_req,
  input  logic [AW-1:0] disp_addr,
  output logic          disp_gnt,
  output logic          disp_valid,
  output logic [7:0]    disp_rdata,
  output logic          ram_we,
  output logic [AW-1:0] ram_addr,
  output logic [7:0]    ram_wdata,
  input  logic [7:0]    ram_rdata
);
  typedef enum logic {IDLE, WRITE} state_t;
  state_t        state_q, state_d;
  logic [3:0]    mask_q, mask_d;
  logic          last_cpu_q, last_cpu_d;
  logic          disp_valid_q;
  logic [AW-3:0] addr_q, addr_d;
  logic [31:0]   data_q, data_d;
  logic [1:0]    lane;
  logic          cpu_gnt, accept;
  logic          unused;
  assign unused = ^{cpu_addr[31:AW], cpu_addr[1:0]};
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      mask_q       <= '0;
      last_cpu_q   <= 1'b1;
      disp_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      mask_q       <= mask_d;
      last_cpu_q   <= last_cpu_d;
      disp_valid_q <= disp_gnt;
    end
    addr_q <= addr_d;
    data_q <= data_d;
  end
  // Lanes leave the mask as they are written; the word is done when the mask empties.
  always_comb begin
    accept     = cpu_req & cpu_ready & (|cpu_be);
    addr_d     = accept ? cpu_addr[AW-1:2] : addr_q;
    data_d     = accept ? cpu_wdata : data_q;
    mask_d     = accept ? cpu_be : cpu_gnt ? mask_q & ~(4'b0001 << lane) : mask_q;
    last_cpu_d = (state_q == WRITE && disp_req) ? cpu_gnt : last_cpu_q;
    state_d    = accept ? WRITE : (cpu_gnt && mask_d == 4'b0000) ? IDLE : state_q;
  end
  // With both requesting, whoever did not win the last conflict goes now.
  always_comb begin
    cpu_ready  = rst_n & (state_q == IDLE);
    lane       = mask_q[0] ? 2'd0 : mask_q[1] ? 2'd1 : mask_q[2] ? 2'd2 : 2'd3;
    cpu_gnt    = rst_n & (state_q == WRITE) & (~disp_req | ~last_cpu_q);
    disp_gnt   = disp_req & ~cpu_gnt;
    ram_we     = cpu_gnt;
    ram_addr   = cpu_gnt ? {addr_q, lane} : disp_addr;
    ram_wdata  = data_q[{~lane, 3'b000} +: 8];
    disp_valid = disp_valid_q;
    disp_rdata = ram_rdata;
  end
endmodule

// File: tb/tb_asciiram_arbiter.sv
// tb_asciiram_arbiter: directed scenario tasks against a behavioural synchronous ASCII RAM.
module tb_asciiram_arbiter;
  localparam int AW = 11;
  logic          clk = 1'b0, rst_n = 1'b0, cpu_req = 1'b0, disp_req = 1'b0;
  logic [31:0]   cpu_addr = '0, cpu_wdata = '0;
  logic [3:0]    cpu_be = '0;
  logic [AW-1:0] disp_addr = '0;
  logic          cpu_ready, disp_gnt, disp_valid, ram_we;
  logic [7:0]    disp_rdata, ram_wdata, ram_rdata;
  logic [AW-1:0] ram_addr;
  bit            written [2048];
  logic [7:0]    mem [2048];
  int            wcount = 0;
  int            errors = 0, checks = 0;

  asciiram_arbiter #(.AW(AW)) dut (
    .clk(clk), .rst_n(rst_n), .cpu_req(cpu_req), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_be(cpu_be), .cpu_ready(cpu_ready), .disp_req(disp_req), .disp_addr(disp_addr),
    .disp_gnt(disp_gnt), .disp_valid(disp_valid), .disp_rdata(disp_rdata), .ram_we(ram_we),
    .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
  );

  always #5 clk = ~clk;

  // Unwritten locations read back as (addr[7:0] ^ 0xA5).
  always @(posedge clk) begin
    if (ram_we) begin
      mem[ram_addr]     <= ram_wdata;
      written[ram_addr] <= 1'b1;
      wcount            <= wcount + 1;
    end
    ram_rdata <= written[ram_addr] ? mem[ram_addr] : (ram_addr[7:0] ^ 8'hA5);
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; cpu_req = 1'b1; cpu_be = 4'hF; cpu_addr = 32'h0; cpu_wdata = 32'h0;
    tick(); tick();
    #1;
    checks++; if (cpu_ready !== 1'b0) begin errors++; $display("FAIL reset_ready got %b exp 0", cpu_ready); end
    checks++; if (ram_we !== 1'b0) begin errors++; $display("FAIL reset_we got %b exp 0", ram_we); end
    checks++; if (disp_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b exp 0", disp_valid); end
    tick();
    cpu_req = 1'b0; rst_n = 1'b1;
    #1;
    checks++; if (cpu_ready !== 1'b1) begin errors++; $display("FAIL reset_release_ready got %b exp 1", cpu_ready); end
    checks++; if (wcount !== 0) begin errors++; $display("FAIL reset_no_write got %0d exp 0", wcount); end
    tick();
  endtask

  task automatic test_full_word();
    cpu_req = 1'b1; cpu_addr = 32'h0000_0104; cpu_wdata = 32'h4142_4344; cpu_be = 4'hF;
    #1;
    checks++; if (cpu_ready !== 1'b1) begin errors++; $display("FAIL full_accept_ready got %b exp 1", cpu_ready); end
    tick();
    cpu_req = 1'b0;
    for (int i = 0; i < 4; i++) begin
      #1;
      checks++; if (ram_we !== 1'b1) begin errors++; $display("FAIL full_we[%0d] got %b exp 1", i, ram_we); end
      checks++; if (ram_addr !== 11'(11'h104 + i)) begin errors++; $display("FAIL full_addr[%0d] got %h exp %h", i, ram_addr, 11'(11'h104 + i)); end
      checks++; if (ram_wdata !== 8'(8'h41 + i)) begin errors++; $display("FAIL full_data[%0d] got %h exp %h", i, ram_wdata, 8'(8'h41 + i)); end
      checks++; if (cpu_ready !== 1'b0) begin errors++; $display("FAIL full_busy[%0d] got %b exp 0", i, cpu_ready); end
      tick();
    end
    #1;
    checks++; if (cpu_ready !== 1'b1) begin errors++; $display("FAIL full_ready_c5 got %b exp 1", cpu_ready); end
    checks++; if (ram_we !== 1'b0) begin errors++; $display("FAIL full_done_we got %b exp 0", ram_we); end
    tick();
  endtask

  task automatic test_sparse();
    logic [10:0] ea [2];
    logic [7:0]  ed [2];
    ea = '{11'h021, 11'h023}; ed = '{8'h11, 8'h33};
    cpu_req = 1'b1; cpu_addr = 32'h20; cpu_wdata = 32'h0011_2233; cpu_be = 4'b1010;
    #1; tick();
    cpu_req = 1'b0;
    for (int i = 0; i < 2; i++) begin
      #1;
      checks++; if (ram_we !== 1'b1) begin errors++; $display("FAIL sparse_we[%0d] got %b exp 1", i, ram_we); end
      checks++; if (ram_addr !== ea[i]) begin errors++; $display("FAIL sparse_addr[%0d] got %h exp %h", i, ram_addr, ea[i]); end
      checks++; if (ram_wdata !== ed[i]) begin errors++; $display("FAIL sparse_data[%0d] got %h exp %h", i, ram_wdata, ed[i]); end
      tick();
    end
    #1;
    checks++; if (cpu_ready !== 1'b1) begin errors++; $display("FAIL sparse_ready got %b exp 1", cpu_ready); end
    tick();
  endtask

  task automatic test_contention();
    logic [7:0]    eb [4];
    logic          prev_d, exp_d;
    logic [AW-1:0] prev_a;
    eb = '{8'hDE, 8'hAD, 8'hBE, 8'hEF};
    cpu_req = 1'b1; cpu_addr = 32'h40; cpu_wdata = 32'hDEAD_BEEF; cpu_be = 4'hF;
    disp_req = 1'b1; disp_addr = 11'h300;
    #1;
    checks++; if (disp_gnt !== 1'b1) begin errors++; $display("FAIL cont_idle_gnt got %b exp 1", disp_gnt); end
    prev_d = 1'b1; prev_a = 11'h300;
    tick();
    cpu_req = 1'b0;
    for (int c = 0; c < 8; c++) begin
      disp_addr = 11'(11'h301 + c);
      exp_d = (c % 2 == 0);
      #1;
      checks++; if (disp_gnt !== exp_d) begin errors++; $display("FAIL cont_gnt[%0d] got %b exp %b", c, disp_gnt, exp_d); end
      checks++; if (ram_we !== !exp_d) begin errors++; $display("FAIL cont_we[%0d] got %b exp %b", c, ram_we, !exp_d); end
      if (!exp_d) begin
        checks++; if (ram_addr !== 11'(11'h40 + c / 2)) begin errors++; $display("FAIL cont_addr[%0d] got %h exp %h", c, ram_addr, 11'(11'h40 + c / 2)); end
        checks++; if (ram_wdata !== eb[c / 2]) begin errors++; $display("FAIL cont_data[%0d] got %h exp %h", c, ram_wdata, eb[c / 2]); end
      end
      checks++; if (disp_valid !== prev_d) begin errors++; $display("FAIL cont_valid[%0d] got %b exp %b", c, disp_valid, prev_d); end
      if (prev_d) begin
        checks++; if (disp_rdata !== (prev_a[7:0] ^ 8'hA5)) begin errors++; $display("FAIL cont_rdata[%0d] got %h exp %h", c, disp_rdata, prev_a[7:0] ^ 8'hA5); end
      end
      prev_d = exp_d; prev_a = disp_addr;
      tick();
    end
    disp_req = 1'b0;
    #1;
    checks++; if (cpu_ready !== 1'b1) begin errors++; $display("FAIL cont_ready got %b exp 1", cpu_ready); end
    checks++; if (disp_valid !== 1'b0) begin errors++; $display("FAIL cont_last_valid got %b exp 0", disp_valid); end
    tick();
  endtask

  task automatic test_reset_mid();
    int w0;
    #1; w0 = wcount;
    cpu_req = 1'b1; cpu_addr = 32'h80; cpu_wdata = 32'h0102_0304; cpu_be = 4'hF;
    tick();
    cpu_req = 1'b0; disp_req = 1'b1;
    #1;
    checks++; if (disp_gnt !== 1'b1 || ram_we !== 1'b0) begin errors++; $display("FAIL mid_first_conflict got gnt=%b we=%b exp gnt=1 we=0", disp_gnt, ram_we); end
    tick();
    disp_req = 1'b0;
    for (int i = 0; i < 2; i++) begin
      #1;
      checks++; if (ram_we !== 1'b1 || ram_addr !== 11'(11'h80 + i) || ram_wdata !== 8'(i + 1)) begin
        errors++; $display("FAIL mid_write[%0d] got we=%b addr=%h data=%h exp we=1 addr=%h data=%h", i, ram_we, ram_addr, ram_wdata, 11'(11'h80 + i), 8'(i + 1));
      end
      tick();
    end
    rst_n = 1'b0;
    #1;
    checks++; if (ram_we !== 1'b0 || cpu_ready !== 1'b0) begin errors++; $display("FAIL mid_in_reset got we=%b ready=%b exp 0 0", ram_we, cpu_ready); end
    tick();
    rst_n = 1'b1;
    #1;
    checks++; if (cpu_ready !== 1'b1 || ram_we !== 1'b0) begin errors++; $display("FAIL mid_after_reset got ready=%b we=%b exp 1 0", cpu_ready, ram_we); end
    cpu_req = 1'b1; cpu_addr = 32'h90; cpu_wdata = 32'h5500_0000; cpu_be = 4'h1; disp_req = 1'b1;
    tick();
    cpu_req = 1'b0;
    #1;
    checks++; if (disp_gnt !== 1'b1 || ram_we !== 1'b0) begin errors++; $display("FAIL mid_last_gnt got gnt=%b we=%b exp gnt=1 we=0", disp_gnt, ram_we); end
    tick();
    #1;
    checks++; if (ram_we !== 1'b1 || ram_addr !== 11'h090 || ram_wdata !== 8'h55) begin
      errors++; $display("FAIL mid_post_write got we=%b addr=%h data=%h exp 1 090 55", ram_we, ram_addr, ram_wdata);
    end
    disp_req = 1'b0;
    tick();
    #1;
    checks++; if (wcount !== w0 + 3) begin errors++; $display("FAIL mid_write_count got %0d exp %0d", wcount - w0, 3); end
    tick();
  endtask

  task automatic test_back_to_back();
    int w0;
    #1; w0 = wcount;
    cpu_req = 1'b1; cpu_addr = 32'h10; cpu_wdata = 32'h7700_0000; cpu_be = 4'h0;
    tick();
    #1;
    checks++; if (cpu_ready !== 1'b1 || ram_we !== 1'b0 || wcount !== w0) begin
      errors++; $display("FAIL zero_be got ready=%b we=%b writes=%0d exp 1 0 0", cpu_ready, ram_we, wcount - w0);
    end
    cpu_be = 4'h1;
    tick();
    #1;
    checks++; if (ram_we !== 1'b1 || ram_addr !== 11'h010 || ram_wdata !== 8'h77 || cpu_ready !== 1'b0) begin
      errors++; $display("FAIL b2b_first got we=%b addr=%h data=%h ready=%b exp 1 010 77 0", ram_we, ram_addr, ram_wdata, cpu_ready);
    end
    tick();
    #1;
    checks++; if (cpu_ready !== 1'b1 || ram_we !== 1'b0) begin errors++; $display("FAIL b2b_gap got ready=%b we=%b exp 1 0", cpu_ready, ram_we); end
    tick();
    #1;
    checks++; if (ram_we !== 1'b1 || ram_addr !== 11'h010) begin errors++; $display("FAIL b2b_second got we=%b addr=%h exp 1 010", ram_we, ram_addr); end
    cpu_req = 1'b0;
    tick();
  endtask

  task automatic test_alias();
    cpu_req = 1'b1; cpu_addr = 32'hFFFF_F804; cpu_wdata = 32'h6162_6364; cpu_be = 4'hF;
    #1; tick();
    cpu_req = 1'b0;
    for (int i = 0; i < 4; i++) begin
      #1;
      checks++; if (ram_we !== 1'b1 || ram_addr !== 11'(4 + i) || ram_wdata !== 8'(8'h61 + i)) begin
        errors++; $display("FAIL alias[%0d] got we=%b addr=%h data=%h exp 1 %h %h", i, ram_we, ram_addr, ram_wdata, 11'(4 + i), 8'(8'h61 + i));
      end
      tick();
    end
    #1;
    checks++; if (cpu_ready !== 1'b1) begin errors++; $display("FAIL alias_ready got %b exp 1", cpu_ready); end
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL timeout got running exp finished");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_full_word();
    test_sparse();
    test_contention();
    test_reset_mid();
    test_back_to_back();
    test_alias();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
